// File: rtl/lcd_vram_arbiter.sv
// VRAM arbiter between the LCD scanout prefetcher (fixed priority) and a host
// port, with a starvation guard and a tag pipeline routing read data back.
module lcd_vram_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STARVE = 8
) (
  input  logic              PixelClk,
  input  logic              nRST,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              disp_urgent,
  output logic              disp_ack,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              host_valid,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [7:0] STARVE_LIM = 8'(MAX_STARVE);

  // Handshakes: a host request transfers in a cycle where host_valid and
  // host_ready are both high; a scanout request transfers where disp_req and
  // disp_ack are both high. The requester must hold its fields until then.
  logic [7:0] starve_cnt;
  logic       force_host;
  logic       grant_host;
  logic       grant_disp;
  logic       issue_rd;

  always_comb begin
    force_host = (starve_cnt == STARVE_LIM) && host_valid && !disp_urgent;
    grant_host = nRST && host_valid && (force_host || !disp_req);
    grant_disp = nRST && disp_req && !grant_host;
    issue_rd   = grant_disp || (grant_host && !host_we);
  end

  assign disp_ack   = grant_disp;
  assign host_ready = grant_host;

  // Counts consecutive denied host cycles; stays at the limit while urgent.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      starve_cnt <= '0;
    end else if (!host_valid || grant_host) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_ce <= grant_host || grant_disp;
      if (grant_host) begin
        mem_we    <= host_we;
        mem_addr  <= host_addr;
        mem_wdata <= host_wdata;
      end else if (grant_disp) begin
        mem_we   <= 1'b0;
        mem_addr <= disp_addr;
      end
    end
  end

  // Stage k holds the tag of the access issued k+1 cycles ago; the last stage
  // lines up with mem_rdata for that access.
  logic [MEM_LAT:0] tag_vld;
  logic [MEM_LAT:0] tag_host;

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      tag_vld  <= '0;
      tag_host <= '0;
    end else begin
      tag_vld  <= {tag_vld[MEM_LAT-1:0], issue_rd};
      tag_host <= {tag_host[MEM_LAT-1:0], grant_host};
    end
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      host_rvalid <= 1'b0;
      disp_rvalid <= 1'b0;
      host_rdata  <= '0;
      disp_rdata  <= '0;
    end else begin
      host_rvalid <= tag_vld[MEM_LAT] && tag_host[MEM_LAT];
      disp_rvalid <= tag_vld[MEM_LAT] && !tag_host[MEM_LAT];
      if (tag_vld[MEM_LAT] && tag_host[MEM_LAT]) begin
        host_rdata <= mem_rdata;
      end
      if (tag_vld[MEM_LAT] && !tag_host[MEM_LAT]) begin
        disp_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: doc/lcd_vram_arbiter.md
Name: lcd_vram_arbiter

Overview:
- Shares one single-port video RAM (RGB565 framebuffer, 480x272) between two requesters: the LCD scanout prefetcher (real-time, read-only) and a host port (read/write, valid/ready).
- Scanout has fixed priority. A starvation guard gives the host one slot after a bounded wait, unless scanout signals urgency.
- A tag pipeline routes read data back to the requester that issued the read.
- Sits between the timing/pixel generator and the VRAM macro.

Parameters:
- ADDR_W, 17, word address width (480*272 = 130560 words).
- DATA_W, 16, pixel word width (RGB565).
- MEM_LAT, 1, VRAM read latency in cycles, from mem_ce to valid mem_rdata (1..4).
- MAX_STARVE, 8, consecutive denied host cycles before a forced host slot (1..255).

Ports:
- PixelClk  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- disp_req  in  1  scanout read request.
- disp_addr  in  ADDR_W  scanout read address.
- disp_urgent  in  1  scanout FIFO below low watermark; blocks forced host slots.
- disp_ack  out  1  scanout request accepted this cycle (combinational).
- disp_rvalid  out  1  scanout read data valid.
- disp_rdata  out  DATA_W  scanout read data.
- host_valid  in  1  host request valid.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_ready  out  1  host request accepted this cycle (combinational).
- host_rvalid  out  1  host read data valid.
- host_rdata  out  DATA_W  host read data.
- mem_ce  out  1  VRAM access enable.
- mem_we  out  1  VRAM write enable.
- mem_addr  out  ADDR_W  VRAM address.
- mem_wdata  out  DATA_W  VRAM write data.
- mem_rdata  in  DATA_W  VRAM read data.

Behaviour:
- Reset values: all outputs 0; starve_cnt 0; tag pipeline cleared.
- Reset asserted mid-operation drops in-flight reads: no rvalid is produced for them after reset release.
- Grant, per cycle:
  - force = (starve_cnt == MAX_STARVE) && host_valid && !disp_urgent.
  - grant_host = host_valid && (force || !disp_req).
  - grant_disp = disp_req && !grant_host.
  - disp_ack = grant_disp; host_ready = grant_host.
  - At most one grant per cycle. The arbiter is idle when neither requester is active.
- Issue: an access accepted in cycle t drives registered mem_ce, mem_we, mem_addr, mem_wdata in cycle t+1.
  - mem_ce = 0 in cycles following an idle cycle; mem_we, mem_addr, mem_wdata are don't-care but held at their last values.
- Return:
  - A MEM_LAT+1 deep tag shift register records {valid, is_host} for each read. Writes insert valid = 0.
  - Read data is registered to the owning requester. rvalid is high for exactly one cycle at t+2+MEM_LAT (t+3 with the defaults).
  - The non-owning rvalid stays 0; the non-owning rdata holds its previous value.
  - Read data is returned in issue order; back-to-back reads give one rvalid per cycle.
- Starvation counter (8-bit, saturating at MAX_STARVE):
  - Increments each cycle with host_valid && !host_ready.
  - Clears to 0 on host acceptance or whenever host_valid = 0.
  - At MAX_STARVE with disp_urgent = 1 it holds at MAX_STARVE. The host is granted in the first cycle disp_urgent drops or disp_req drops.
- Host handshake rules:
  - host_valid must stay high with stable fields until accepted.
  - Dropping host_valid before acceptance is tolerated: no access is issued and the counter clears.
- disp_req may change freely every cycle. A request is consumed only when disp_ack = 1.
- Simultaneous requests with the counter below the limit: scanout wins.
- Address and data pass through unmodified; no width conversion and no range checking.

Test Plan:
1. Reset, then a host write (addr 0x00010, data 0xF800) with disp_req = 0: host_ready = 1 the same cycle; next cycle mem_ce = 1, mem_we = 1, mem_addr = 0x00010, mem_wdata = 0xF800; no rvalid.
2. Host read of 0x00010 with the memory model returning 0xF800: host_rvalid pulses 3 cycles after acceptance with host_rdata = 0xF800; disp_rvalid stays 0.
3. disp_req held high continuously with addresses 0..20 and host_valid high: scanout is acked on cycles 0..7; the host gets the cycle-8 slot; scanout resumes on cycle 9; disp_rdata returns the expected words in address order.
4. Same as 3 but disp_urgent = 1 for 20 cycles: the host is never granted and starve_cnt holds at 8. Drop disp_urgent: host_ready = 1 that cycle.
5. Alternating scanout and host reads back-to-back: each rvalid is routed to the correct port in issue order, with no lost or duplicated pulses.
6. Assert nRST with 2 reads in flight: all outputs go to 0 immediately; after release, no rvalid appears for the dropped reads.
